// File: rtl/seq_det_pkg.sv
// Shared types and constants for the time-shared "1011" sequence detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/seq_det_core.sv
// Combinational Mealy "1011" detector step: one state and one bit in, next state and match out.
module seq_det_core
    import seq_det_pkg::*;
(
    input  state_t state,
    input  logic   in_bit,
    output state_t next_state,
    output logic   match
);

    // Next-state table and overlapping Mealy match
    always_comb begin
        next_state = S0;
        match      = 1'b0;
        case (state)
            S0: begin
                if (in_bit) next_state = S1;
                else        next_state = S0;
            end
            S1: begin
                if (in_bit) next_state = S1;
                else        next_state = S2;
            end
            S2: begin
                if (in_bit) next_state = S3;
                else        next_state = S0;
            end
            S3: begin
                if (in_bit) next_state = S1;
                else        next_state = S2;
                match = (in_bit == PATTERN[0]);
            end
            default: begin
                next_state = S0;
                match      = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_det_arbiter.sv
// Round-robin time-sharing of one sequence-detector core across NCH serial streams,
// with per-channel saved context, a registered result port and a saturating match counter.
module seq_det_arbiter
    import seq_det_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int CHW  = $clog2(NCH),
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NCH-1:0]  in_valid,
    input  logic [NCH-1:0]  in_bit,
    output logic [NCH-1:0]  in_ready,
    input  logic [NCH-1:0]  ch_clr,
    output logic            out_valid,
    output logic [CHW-1:0]  out_ch,
    output logic            out_match,
    output logic [CNTW-1:0] match_cnt
);

    state_t          ctx_r [NCH];
    logic [CHW-1:0]  ptr_r;
    logic            out_valid_r;
    logic [CHW-1:0]  out_ch_r;
    logic            out_match_r;
    logic [CNTW-1:0] match_cnt_r;

    logic            gnt_any_s;
    logic [CHW-1:0]  gnt_idx_s;
    logic [NCH-1:0]  grant_s;
    state_t          core_state_s;
    logic            core_bit_s;
    state_t          core_next_s;
    logic            core_match_s;
    logic            match_eff_s;

    // Round-robin search starting just after the last granted channel
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_idx_s = '0;
        for (int k = 1; k <= NCH; k++) begin
            int idx_v;
            idx_v = (int'(ptr_r) + k) % NCH;
            if (!gnt_any_s && in_valid[idx_v]) begin
                gnt_any_s = 1'b1;
                gnt_idx_s = CHW'(idx_v);
            end else begin
                gnt_any_s = gnt_any_s;
            end
        end
    end

    // One-hot grant vector
    always_comb begin
        grant_s = '0;
        if (gnt_any_s) begin
            grant_s = {{(NCH-1){1'b0}}, 1'b1} << gnt_idx_s;
        end else begin
            grant_s = '0;
        end
    end

    assign in_ready = grant_s;

    // Feed the granted channel's saved context into the shared core
    always_comb begin
        core_state_s = ctx_r[gnt_idx_s];
        core_bit_s   = in_bit[gnt_idx_s];
    end

    seq_det_core u_core (
        .state      (core_state_s),
        .in_bit     (core_bit_s),
        .next_state (core_next_s),
        .match      (core_match_s)
    );

    // A same-cycle clear on the granted channel suppresses its match
    always_comb begin
        match_eff_s = 1'b0;
        if (gnt_any_s && !ch_clr[gnt_idx_s]) begin
            match_eff_s = core_match_s;
        end else begin
            match_eff_s = 1'b0;
        end
    end

    // Context file: clear wins over write-back of the core's next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                ctx_r[i] <= S0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_clr[i]) begin
                    ctx_r[i] <= S0;
                end else if (gnt_any_s && (gnt_idx_s == CHW'(i))) begin
                    ctx_r[i] <= core_next_s;
                end else begin
                    ctx_r[i] <= ctx_r[i];
                end
            end
        end
    end

    // Round-robin pointer; starts at NCH-1 so channel 0 is searched first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= CHW'(NCH - 1);
        end else if (gnt_any_s) begin
            ptr_r <= gnt_idx_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Result register; channel and match hold across idle cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_ch_r    <= '0;
            out_match_r <= 1'b0;
        end else if (gnt_any_s) begin
            out_valid_r <= 1'b1;
            out_ch_r    <= gnt_idx_s;
            out_match_r <= match_eff_s;
        end else begin
            out_valid_r <= 1'b0;
            out_ch_r    <= out_ch_r;
            out_match_r <= out_match_r;
        end
    end

    // Saturating match counter, updated alongside the registered match
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_cnt_r <= '0;
        end else if (match_eff_s && (match_cnt_r != {CNTW{1'b1}})) begin
            match_cnt_r <= match_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            match_cnt_r <= match_cnt_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_ch    = out_ch_r;
    assign out_match = out_match_r;
    assign match_cnt = match_cnt_r;

endmodule

// File: doc/seq_det_arbiter.md
Name: seq_det_arbiter

Overview:
- Time-shares one 4-state "1011" Mealy sequence-detector core among NCH independent serial bit streams.
- Round-robin arbiter picks one valid requester per cycle; that channel's saved detector state is fed to the core, and the core's next state is written back.
- Per-channel state is kept in a context register file, so each stream behaves as if it had a private detector.
- Sits between NCH serial front-ends and a single match-event consumer; also keeps a global saturating match counter.

Parameters:
- NCH, 4, number of requesting bit streams (2..16).
- CHW, $clog2(NCH), width of the channel index.
- CNTW, 16, width of the saturating match counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  NCH  per-channel bit-valid request.
- in_bit  input  NCH  per-channel serial data bit.
- in_ready  output  NCH  one-hot grant; a bit is consumed when in_valid[i] and in_ready[i] are both high.
- ch_clr  input  NCH  synchronous per-channel context clear.
- out_valid  output  1  registered result strobe.
- out_ch  output  CHW  channel of the registered result.
- out_match  output  1  registered: 1 = the consumed bit completed "1011".
- match_cnt  output  CNTW  total matches over all channels, saturating.

Behaviour:
- Reset (async, active-high):
  - all contexts = S0;
  - RR pointer = NCH-1, so channel 0 has priority first;
  - out_valid = 0, out_ch = 0, out_match = 0, match_cnt = 0.
- States (2-bit): S0=00 idle, S1=01 seen "1", S2=10 seen "10", S3=11 seen "101".
- Transitions, in_bit 0 / 1:
  - S0 -> S0 / S1
  - S1 -> S2 / S1
  - S2 -> S0 / S3
  - S3 -> S2 / S1
- Mealy match = (state==S3) && in_bit==1. Overlap is allowed: "1011011" gives 2 matches.
- Arbitration:
  - in_ready is combinational from in_valid and the RR pointer.
  - Grant goes to the first i with in_valid[i]=1, searching (ptr+1) mod NCH upward.
  - At most one bit of in_ready is set. in_ready = 0 when no request.
  - ptr <= granted index on each grant; ptr holds when idle.
- Cycle N, grant to ch g:
  - ctx[g] <= next_state;
  - at edge N+1: out_valid=1, out_ch=g, out_match=match.
  - Latency is 1 cycle. Throughput is 1 bit/cycle total.
- No grant in cycle N: out_valid=0 at N+1; out_ch and out_match hold their last values.
- match_cnt increments by 1 on each registered match and saturates at 2^CNTW-1 (no wrap).
- ch_clr[i]=1: ctx[i] <= S0 at the next edge. Takes priority over a same-cycle grant to i:
  - the bit is still consumed (in_ready[i] stays per arbiter);
  - the result is out_valid=1, out_match=0;
  - the context ends at S0.
- ch_clr on a non-granted channel does not affect the granted channel.
- Fairness: with all NCH requesting continuously, each channel is granted exactly once every NCH cycles.
- Reset asserted mid-stream clears all contexts immediately. Partial sequences are lost and there is no spurious out_valid.
- Requesters may drop in_valid without a grant; nothing is latched for un-granted channels.

Decomposition:
- Shared package seq_det_pkg: state typedef/localparams S0..S3 and the pattern constant 4'b1011.
- Sub-module seq_det_core (purely combinational):
  - inputs: state, in_bit;
  - outputs: next_state, match.
- The arbiter, context file, output register and counter live in seq_det_arbiter.

Test Plan:
- Reset then ch0 alone sends 1,0,1,1 on 4 consecutive cycles -> out_valid 4 cycles, out_ch=0, out_match=0,0,0,1 (match lands on the 4th result, one cycle after the last bit); match_cnt=1.
- All 4 channels hold in_valid=1 -> in_ready grants 0,1,2,3,0,... one-hot. Interleaved "1011" per channel gives exactly one match per channel; match_cnt=4.
- ch1 sends 1,0,1,1,0,1,1 (overlap) -> out_match pattern 0,0,0,1,0,0,1; ctx[1] ends S1.
- ch2 sends 1,0,1, then ch_clr[2] together with granted bit 1 -> out_valid=1, out_match=0. A following 1,0,1,1 -> match only on the final bit.
- Assert reset while ch3 is in S3 and ch0 is in S2, then send 1 on ch3 -> no match; out_valid=0 during reset; match_cnt=0.
- Force match_cnt to 16'hFFFE, then 3 matches -> counter reads FFFF, FFFF, FFFF (saturates, no wrap).
